// File: rtl/clb_cfg_pkg.sv
// Shared constants and state encoding for the CLB configuration loader.
// The optional parity feature is controlled by the CLB_CFG_PARITY_EN macro.
package clb_cfg_pkg;

  localparam int CFG_W = 18;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/clb_cfg_shift.sv
// Shadow shift register for the CLB configuration payload.
// Bits of a word are collected MSB first in an accumulator; each completed
// word is pushed in at the top of the shadow and everything moves down by one
// word, so after NUM_CLB words word 0 sits in the low slice.
// With CLB_CFG_PARITY_EN defined, every word carries a trailing even-parity
// bit which is checked here but never stored.
module clb_cfg_shift #(
  parameter int NUM_CLB = 4,
  parameter int CFG_W   = clb_cfg_pkg::CFG_W
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     clr_i,
  input  logic                     shift_i,
  input  logic                     bit_i,
  output logic [NUM_CLB*CFG_W-1:0] shadow_o,
  output logic                     word_last_o,
  output logic                     frame_last_o,
  output logic                     par_bit_o,
  output logic                     par_ok_o
);

  localparam int TOT_W = NUM_CLB * CFG_W;
  localparam int BCW   = $clog2(CFG_W + 1);
  localparam int WCW   = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

`ifdef CLB_CFG_PARITY_EN
  localparam logic [BCW-1:0] LAST_BIT = BCW'(CFG_W);
`else
  localparam logic [BCW-1:0] LAST_BIT = BCW'(CFG_W - 1);
`endif
  localparam logic [BCW-1:0] LAST_DATA = BCW'(CFG_W - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_CLB - 1);

  logic [TOT_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] acc_q, acc_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic             data_bit;

  assign data_bit     = (bit_cnt_q <= LAST_DATA);
  assign word_last_o  = (bit_cnt_q == LAST_BIT);
  assign frame_last_o = word_last_o && (word_cnt_q == LAST_WORD);
  assign shadow_o     = shadow_q;

`ifdef CLB_CFG_PARITY_EN
  logic par_q, par_d;

  assign par_bit_o = !data_bit;
  assign par_ok_o  = (bit_i == par_q);

  // Running XOR of the current word's data bits
  always_comb begin
    par_d = par_q;
    if (clr_i) begin
      par_d = 1'b0;
    end else if (shift_i) begin
      if (data_bit) begin
        par_d = par_q ^ bit_i;
      end else if (!frame_last_o) begin
        par_d = 1'b0;
      end
    end
  end

  // Parity accumulator register
  always_ff @(posedge clk) begin
    if (res) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign par_bit_o = 1'b0;
  assign par_ok_o  = 1'b1;
`endif

  // Next-state for accumulator, shadow and bit/word counters
  always_comb begin
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (clr_i) begin
      shadow_d   = '0;
      acc_d      = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (shift_i) begin
      if (data_bit) begin
        acc_d = {acc_q[CFG_W-2:0], bit_i};
        if (bit_cnt_q == LAST_DATA) begin
          shadow_d = shadow_q >> CFG_W;
          shadow_d[TOT_W-1 -: CFG_W] = acc_d;
        end
      end
      // Counters stop at their terminal values on the final bit of the frame
      if (word_last_o) begin
        if (!frame_last_o) begin
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Shadow, accumulator and counter registers
  always_ff @(posedge clk) begin
    if (res) begin
      shadow_q   <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: rtl/clb_config_loader.sv
// CLB configuration loader: hunts for a sync word in a serial bitstream,
// shifts NUM_CLB configuration words into a shadow register and commits them
// to sram_data in a single cycle so CLBs never see a partial configuration.
// Define CLB_CFG_PARITY_EN to expect and check an even-parity bit per word;
// without it the ERR state is unreachable and cfg_err is tied low.
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int                NUM_CLB   = 4,
  parameter int                CFG_W     = clb_cfg_pkg::CFG_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic [NUM_CLB*CFG_W-1:0] sram_data,
  output logic                     cfg_done,
  output logic                     cfg_err
);

  localparam int TOT_W = NUM_CLB * CFG_W;

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] win_q, win_d;
  logic [TOT_W-1:0]  sram_q, sram_d;
  logic [TOT_W-1:0]  shadow;
  logic              xfer;
  logic              sh_clr;
  logic              sh_shift;
  logic              word_last;
  logic              frame_last;
  logic              par_bit;
  logic              par_ok;
  logic              par_err;

  assign bit_ready = (state_q == ST_SYNC) || (state_q == ST_LOAD);
  assign xfer      = bit_valid && bit_ready;
  assign sh_shift  = xfer && (state_q == ST_LOAD);
  assign par_err   = sh_shift && word_last && par_bit && !par_ok;

  assign sram_data = sram_q;
  assign cfg_done  = (state_q == ST_DONE);
`ifdef CLB_CFG_PARITY_EN
  assign cfg_err   = (state_q == ST_ERR);
`else
  assign cfg_err   = 1'b0;
`endif

  clb_cfg_shift #(
    .NUM_CLB (NUM_CLB),
    .CFG_W   (CFG_W)
  ) u_shift (
    .clk          (clk),
    .res          (res),
    .clr_i        (sh_clr),
    .shift_i      (sh_shift),
    .bit_i        (bit_in),
    .shadow_o     (shadow),
    .word_last_o  (word_last),
    .frame_last_o (frame_last),
    .par_bit_o    (par_bit),
    .par_ok_o     (par_ok)
  );

  // Next state, sync window and commit of the shadow onto sram_data
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sram_d  = sram_q;
    sh_clr  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_SYNC;
          win_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          win_d = {win_q[SYNC_W-2:0], bit_in};
          if (win_d == SYNC_WORD) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (sh_shift) begin
          if (par_err) begin
            state_d = ST_ERR;
            sh_clr  = 1'b1;
          end else if (frame_last) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        sram_d  = shadow;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, sync window and committed configuration registers
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      sram_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      sram_q  <= sram_d;
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Scoreboard bench for clb_config_loader with NUM_CLB=2.
module tb_clb_config_loader;

  localparam int NUM_CLB = 2;
  localparam int CFG_W   = 18;
  localparam int TOT_W   = NUM_CLB * CFG_W;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [TOT_W-1:0] sram_data;
  logic             cfg_done;
  logic             cfg_err;

  always #5 clk = ~clk;

  clb_config_loader #(
    .NUM_CLB (NUM_CLB),
    .CFG_W   (CFG_W)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .sram_data (sram_data),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  typedef struct {
    bit               is_err;
    logic [TOT_W-1:0] sram;
  } exp_t;

  exp_t             exp_q[$];
  bit               stream_q[$];
  logic [CFG_W-1:0] words[NUM_CLB];
  logic [TOT_W-1:0] committed;
  int               checks   = 0;
  int               failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: the configuration image is simply the words laid side by side
  function automatic logic [TOT_W-1:0] image();
    logic [TOT_W-1:0] v = '0;
    for (int k = 0; k < NUM_CLB; k++) v[k*CFG_W +: CFG_W] = words[k];
    return v;
  endfunction

  // Reference sync search: index just past the first 8-bit window equal to A5
  function automatic int sync_end();
    logic [7:0] w = 8'h00;
    for (int i = 0; i < stream_q.size(); i++) begin
      w = {w[6:0], stream_q[i]};
      if (w == 8'hA5) return i + 1;
    end
    return -1;
  endfunction

  task automatic build(input int glen, input logic [15:0] gbits, input int bad_word);
    logic [7:0] sw = 8'hA5;
    stream_q.delete();
    for (int i = glen - 1; i >= 0; i--) stream_q.push_back(gbits[i]);
    for (int i = 7; i >= 0; i--) stream_q.push_back(sw[i]);
    for (int k = 0; k < NUM_CLB; k++) begin
      for (int i = CFG_W - 1; i >= 0; i--) stream_q.push_back(words[k][i]);
`ifdef CLB_CFG_PARITY_EN
      stream_q.push_back((^words[k]) ^ (k == bad_word));
`endif
      if (k == bad_word) break;
    end
  endtask

  task automatic xfer(input bit b);
    int guard = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (bit_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("xfer_timeout", 64'(guard), 64'(0));
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last accepted bit
  task automatic send_frame(input int pay0, input bit stall, input int start_at, input int nbits);
    int n = (nbits < 0) ? stream_q.size() : nbits;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stall && i >= pay0 && ((i - pay0) % 2) == 1) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        @(negedge clk);
        check("stall_ready", 64'(bit_ready), 64'(1));
      end
      if (i == start_at) start = 1'b1;
      xfer(stream_q[i]);
      start = 1'b0;
    end
  endtask

  task automatic do_load(input logic [CFG_W-1:0] w0, input logic [CFG_W-1:0] w1,
                         input int glen, input logic [15:0] gbits,
                         input bit stall, input int start_at);
    exp_t e;
    words[0] = w0;
    words[1] = w1;
    build(glen, gbits, -1);
    e.is_err = 1'b0;
    e.sram   = image();
    exp_q.push_back(e);
    send_frame(glen + 8, stall, start_at, -1);
    check("hold_before_commit", 64'(sram_data), 64'(committed));
    check("done_low_commit", 64'(cfg_done), 64'(0));
    check("ready_low_commit", 64'(bit_ready), 64'(0));
    @(negedge clk);
    check("sram_after_commit", 64'(sram_data), 64'(e.sram));
    check("done_after_commit", 64'(cfg_done), 64'(1));
    committed = e.sram;
  endtask

  // Monitor: pop an expectation whenever a load completes or fails
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if ((cfg_done === 1'b1 && done_prev !== 1'b1) || (cfg_err === 1'b1 && err_prev !== 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_event", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_kind_err", 64'(cfg_err), 64'(e.is_err));
        check("sb_sram", 64'(sram_data), 64'(e.sram));
      end
    end
    done_prev = cfg_done;
    err_prev  = cfg_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int glen;
    logic [15:0] g;
    int sa;
    res       = 1'b1;
    start     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    committed = '0;
    repeat (2) @(negedge clk);
    res   = 1'b0;
    start = 1'b0;
    check("reset_ready", 64'(bit_ready), 64'(0));
    check("reset_done", 64'(cfg_done), 64'(0));
    check("reset_err", 64'(cfg_err), 64'(0));
    check("reset_sram", 64'(sram_data), 64'(0));
    @(negedge clk);
    check("reset_beats_start", 64'(bit_ready), 64'(0));

    // Basic load
    do_load(18'h00006, 18'h3FFFF, 0, 16'h0, 1'b0, -1);
    check("basic_sram", 64'(sram_data), 64'h0_FFFF_C000_6);
    check("basic_clb0", 64'(sram_data[17:0]), 64'h6);

    // Reload: old value held until commit
    do_load(18'h00001, 18'h00000, 0, 16'h0, 1'b0, -1);
    check("reload_sram", 64'(sram_data), 64'h1);

    // Leading garbage before the sync word
    do_load(18'h00006, 18'h3FFFF, 3, 16'b101, 1'b0, -1);

    // Stalls every other cycle during LOAD
    do_load(18'h2A5A5, 18'h15A5A, 0, 16'h0, 1'b1, -1);

    // Reset mid-load after word0
    words[0] = 18'h12345;
    words[1] = 18'h0BEEF;
    build(0, 16'h0, -1);
    send_frame(8, 1'b0, -1, 8 + CFG_W);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    committed = '0;
    check("midrst_sram", 64'(sram_data), 64'(0));
    check("midrst_ready", 64'(bit_ready), 64'(0));
    check("midrst_done", 64'(cfg_done), 64'(0));
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_accept", 64'(bit_ready), 64'(0));
    end
    bit_valid = 1'b0;
    do_load(18'h12345, 18'h0BEEF, 0, 16'h0, 1'b0, -1);

`ifdef CLB_CFG_PARITY_EN
    begin
      exp_t e;
      words[0] = 18'h00006;
      words[1] = 18'h3FFFF;
      build(0, 16'h0, 0);
      e.is_err = 1'b1;
      e.sram   = committed;
      exp_q.push_back(e);
      send_frame(8, 1'b0, -1, -1);
      check("par_err_flag", 64'(cfg_err), 64'(1));
      check("par_err_sram", 64'(sram_data), 64'(committed));
      check("par_err_ready", 64'(bit_ready), 64'(0));
      check("par_err_done", 64'(cfg_done), 64'(0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("par_err_cleared", 64'(cfg_err), 64'(0));
      check("par_restart_ready", 64'(bit_ready), 64'(1));
      do_load(18'h00006, 18'h3FFFF, 0, 16'h0, 1'b0, -1);
    end
`endif

    // Randomized loads: garbage prefix, stalls, stray start pulses
    for (int it = 0; it < 12; it++) begin
      words[0] = 18'($urandom);
      words[1] = 18'($urandom);
      glen = int'($urandom_range(0, 12));
      g = 16'($urandom);
      for (int t = 0; t < 30; t++) begin
        build(glen, g, -1);
        if (sync_end() == glen + 8) break;
        g = 16'($urandom);
        if (t == 29) glen = 0;
      end
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      do_load(words[0], words[1], glen, g, 1'($urandom), sa);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
